// File: rtl/truth_table_scanner_if.sv
// ---------------------------------------------------------------------------
// truth_table_scanner_if
//
// Groups the stimulus/capture bus between the truth-table scanner and the
// logic that starts it and reads its results.
//
//   master modport : the scanner. It drives stim and the result signals, and
//                    reads start and the two function outputs.
//   slave modport  : the tester side. It drives start and the function
//                    outputs, and reads stim and the results.
//
// Signals:
//   start          begin a scan (honoured only when the scanner is idle)
//   stim[N_IN]     current vector index ({a,b,c,d} / {w,x,y,z}, MSB first)
//   f1_in, f2_in   outputs of the two function blocks under test
//   busy, done     scan in progress / one-cycle completion pulse
//   map_f1/map_f2  sampled minterm maps, V = 2^N_IN bits
//   cnt_f1/cnt_f2  number of ones in each map, N_IN+1 bits
//
// Optional macro TRUTH_TABLE_CHECK_EN adds exp_f1/exp_f2 (expected maps),
// err_f1/err_f2 (map XOR expected) and pass.
// ---------------------------------------------------------------------------
interface truth_table_scanner_if #(
    parameter int N_IN = 4
);
    localparam int V = 1 << N_IN;

    logic              start;
    logic [N_IN-1:0]   stim;
    logic              f1_in;
    logic              f2_in;
    logic              busy;
    logic              done;
    logic [V-1:0]      map_f1;
    logic [V-1:0]      map_f2;
    logic [N_IN:0]     cnt_f1;
    logic [N_IN:0]     cnt_f2;
`ifdef TRUTH_TABLE_CHECK_EN
    logic [V-1:0]      exp_f1;
    logic [V-1:0]      exp_f2;
    logic [V-1:0]      err_f1;
    logic [V-1:0]      err_f2;
    logic              pass;
`endif

    modport master (
        input  start, f1_in, f2_in,
`ifdef TRUTH_TABLE_CHECK_EN
        input  exp_f1, exp_f2,
        output err_f1, err_f2, pass,
`endif
        output stim, busy, done, map_f1, map_f2, cnt_f1, cnt_f2
    );

    modport slave (
        output start, f1_in, f2_in,
`ifdef TRUTH_TABLE_CHECK_EN
        output exp_f1, exp_f2,
        input  err_f1, err_f2, pass,
`endif
        input  stim, busy, done, map_f1, map_f2, cnt_f1, cnt_f2
    );
endinterface

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
//
// Sweeps every N_IN-bit input combination onto a shared stimulus bus, waits
// SETTLE cycles for the combinational blocks to settle, then samples both
// function outputs. Builds a minterm map and a ones count per function and
// signals completion with a one-cycle done pulse. Results hold until the next
// accepted start or reset.
//
// Parameters:
//   N_IN    variables per function (V = 2^N_IN vectors)
//   SETTLE  wait cycles after each stimulus change before sampling (0..15)
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   bus     truth_table_scanner_if.master (start, stim, f1_in, f2_in, busy,
//           done, map_f1, map_f2, cnt_f1, cnt_f2)
//
// Optional macro TRUTH_TABLE_CHECK_EN: latches expected maps on start and
// produces per-bit error maps plus a pass flag set in the DONE cycle.
// ---------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    truth_table_scanner_if.master        bus
);
    localparam int V = 1 << N_IN;

    localparam logic [3:0]      SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [N_IN-1:0] IDX_LAST    = '1;
    localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [3:0]      wait_cnt;
    logic            busy_q;
    logic            done_q;
    logic [V-1:0]    map_f1_q;
    logic [V-1:0]    map_f2_q;
    logic [N_IN:0]   cnt_f1_q;
    logic [N_IN:0]   cnt_f2_q;
`ifdef TRUTH_TABLE_CHECK_EN
    logic [V-1:0]    exp_f1_q;
    logic [V-1:0]    exp_f2_q;
    logic [V-1:0]    err_f1_q;
    logic [V-1:0]    err_f2_q;
    logic            pass_q;
`endif

    // After each sample the scanner moves to the next vector; with no settle
    // time it samples again on the very next cycle.
    localparam state_t ST_AFTER_STEP = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // mixing in blocking assignments would make the result depend on
    // statement order and simulate differently from the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the maps are plain registers, not a RAM, so they can be
            // cleared by reset like any other flop.
            state    <= ST_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            map_f1_q <= '0;
            map_f2_q <= '0;
            cnt_f1_q <= '0;
            cnt_f2_q <= '0;
`ifdef TRUTH_TABLE_CHECK_EN
            exp_f1_q <= '0;
            exp_f2_q <= '0;
            err_f1_q <= '0;
            err_f2_q <= '0;
            pass_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        idx      <= '0;
                        wait_cnt <= '0;
                        map_f1_q <= '0;
                        map_f2_q <= '0;
                        cnt_f1_q <= '0;
                        cnt_f2_q <= '0;
                        busy_q   <= 1'b1;
`ifdef TRUTH_TABLE_CHECK_EN
                        exp_f1_q <= bus.exp_f1;
                        exp_f2_q <= bus.exp_f2;
                        err_f1_q <= '0;
                        err_f2_q <= '0;
                        pass_q   <= 1'b0;
`endif
                        state    <= ST_AFTER_STEP;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == SETTLE_LAST) begin
                        wait_cnt <= '0;
                        state    <= ST_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    map_f1_q[idx] <= bus.f1_in;
                    map_f2_q[idx] <= bus.f2_in;
                    cnt_f1_q      <= cnt_f1_q + {{N_IN{1'b0}}, bus.f1_in};
                    cnt_f2_q      <= cnt_f2_q + {{N_IN{1'b0}}, bus.f2_in};
`ifdef TRUTH_TABLE_CHECK_EN
                    err_f1_q[idx] <= bus.f1_in ^ exp_f1_q[idx];
                    err_f2_q[idx] <= bus.f2_in ^ exp_f2_q[idx];
`endif
                    // idx parks on the last vector rather than wrapping.
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= ST_AFTER_STEP;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
`ifdef TRUTH_TABLE_CHECK_EN
                    // Error maps already hold the last sample at this point.
                    pass_q <= (err_f1_q == '0) && (err_f2_q == '0);
`endif
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stim   = idx;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.map_f1 = map_f1_q;
    assign bus.map_f2 = map_f2_q;
    assign bus.cnt_f1 = cnt_f1_q;
    assign bus.cnt_f2 = cnt_f2_q;
`ifdef TRUTH_TABLE_CHECK_EN
    assign bus.err_f1 = err_f1_q;
    assign bus.err_f2 = err_f2_q;
    assign bus.pass   = pass_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
//
// Two scanners share one clock and reset:
//   dut1 : SETTLE=1, driven by a lookup model of the lab SOP block
//          (f1 minterms 0x35A5, f2 minterms 0xEEE2, optional f2 m6 fault).
//   dut0 : SETTLE=0, f1 tied high, f2 tied low.
// Expected scan results are queued when a start is driven and popped when
// the scanner reports done. Build with +define+TRUTH_TABLE_CHECK_EN to also
// exercise the expected-map comparison outputs.
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;
    localparam int N_IN = 4;

    typedef struct {
        logic [15:0] map_f1;
        logic [15:0] map_f2;
        logic [4:0]  cnt_f1;
        logic [4:0]  cnt_f2;
        int          latency;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] f1_tt;
    logic [15:0] f2_tt;
    logic        force_m6;
    result_t     sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_scanner_if #(.N_IN(N_IN)) bus1 ();
    truth_table_scanner_if #(.N_IN(N_IN)) bus0 ();

    truth_table_scanner #(.N_IN(N_IN), .SETTLE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    truth_table_scanner #(.N_IN(N_IN), .SETTLE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Lab SOP block model for dut1, with an optional stuck-at-0 on f2 m6.
    assign bus1.f1_in = f1_tt[bus1.stim];
    assign bus1.f2_in = f2_tt[bus1.stim] & ~(force_m6 & (bus1.stim == 4'd6));
    assign bus0.f1_in = 1'b1;
    assign bus0.f2_in = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus1.start = v;
        else     bus0.start = v;
    endtask

    function automatic result_t snap(input bit sel);
        result_t r;
        r.map_f1  = sel ? bus1.map_f1 : bus0.map_f1;
        r.map_f2  = sel ? bus1.map_f2 : bus0.map_f2;
        r.cnt_f1  = sel ? bus1.cnt_f1 : bus0.cnt_f1;
        r.cnt_f2  = sel ? bus1.cnt_f2 : bus0.cnt_f2;
        r.latency = 0;
        return r;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? bus1.done : bus0.done;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus1.busy : bus0.busy;
    endfunction

    function automatic logic [3:0] get_stim(input bit sel);
        return sel ? bus1.stim : bus0.stim;
    endfunction

    task automatic push_exp(input logic [15:0] m1, input logic [15:0] m2,
                            input logic [4:0] c1, input logic [4:0] c2, input int lat);
        result_t r;
        r.map_f1  = m1;
        r.map_f2  = m2;
        r.cnt_f1  = c1;
        r.cnt_f2  = c2;
        r.latency = lat;
        sb_q.push_back(r);
    endtask

    // Drives one start, optionally re-pulses start when stim reaches
    // restart_at, waits (bounded) for done and compares against the queue.
    task automatic scan(input bit sel, input bit check_stim, input int restart_at);
        result_t exp_r;
        result_t got_r;
        int      t0;
        int      stim_exp;
        bit      got_done;
        bit      repulse_done;

        set_start(sel, 1'b1);
        tick();
        t0 = cyc;
        set_start(sel, 1'b0);
        check("busy_after_start", {31'd0, get_busy(sel)}, 32'd1);

        got_done     = 1'b0;
        repulse_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (get_done(sel)) begin
                got_done = 1'b1;
                break;
            end
            if (check_stim) begin
                stim_exp = (cyc - t0 > 15) ? 15 : (cyc - t0);
                check("stim_step", {28'd0, get_stim(sel)}, stim_exp);
            end
            if (restart_at >= 0 && !repulse_done && get_stim(sel) == 4'(restart_at)) begin
                set_start(sel, 1'b1);
                tick();
                set_start(sel, 1'b0);
                repulse_done = 1'b1;
            end else begin
                tick();
            end
        end

        check("done_seen", {31'd0, got_done}, 32'd1);
        exp_r = sb_q.pop_front();
        if (got_done) begin
            got_r = snap(sel);
            check("done_latency", cyc - t0, exp_r.latency);
            check("map_f1", {16'd0, got_r.map_f1}, {16'd0, exp_r.map_f1});
            check("map_f2", {16'd0, got_r.map_f2}, {16'd0, exp_r.map_f2});
            check("cnt_f1", {27'd0, got_r.cnt_f1}, {27'd0, exp_r.cnt_f1});
            check("cnt_f2", {27'd0, got_r.cnt_f2}, {27'd0, exp_r.cnt_f2});
            check("busy_at_done", {31'd0, get_busy(sel)}, 32'd0);
            tick();
            check("done_one_cycle", {31'd0, get_done(sel)}, 32'd0);
        end
    endtask

    // Counts done pulses on dut1 over a window; any pulse is unexpected.
    task automatic watch_no_done(input string tag, input int n);
        int pulses = 0;
        for (int k = 0; k < n; k++) begin
            if (bus1.done) pulses++;
            tick();
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        f1_tt      = 16'h35A5;
        f2_tt      = 16'hEEE2;
        force_m6   = 1'b0;
        rst        = 1'b1;
        bus1.start = 1'b1;
        bus0.start = 1'b1;
`ifdef TRUTH_TABLE_CHECK_EN
        bus1.exp_f1 = 16'h35A5;
        bus1.exp_f2 = 16'hEEE2;
        bus0.exp_f1 = 16'h0000;
        bus0.exp_f2 = 16'h0000;
`endif

        // Reset with start held high: nothing may start.
        repeat (3) tick();
        check("rst_busy",   {31'd0, bus1.busy}, 32'd0);
        check("rst_done",   {31'd0, bus1.done}, 32'd0);
        check("rst_stim",   {28'd0, bus1.stim}, 32'd0);
        check("rst_map_f1", {16'd0, bus1.map_f1}, 32'd0);
        check("rst_map_f2", {16'd0, bus1.map_f2}, 32'd0);
        check("rst_cnt_f1", {27'd0, bus1.cnt_f1}, 32'd0);
        check("rst_cnt_f2", {27'd0, bus1.cnt_f2}, 32'd0);
        check("rst_busy0",  {31'd0, bus0.busy}, 32'd0);
        bus1.start = 1'b0;
        bus0.start = 1'b0;
        rst        = 1'b0;
        tick();
        check("idle_after_rst", {31'd0, bus1.busy}, 32'd0);

        // Lab block, SETTLE=1: done at T+33.
        push_exp(16'h35A5, 16'hEEE2, 5'd8, 5'd10, 33);
        scan(1'b1, 1'b0, -1);
`ifdef TRUTH_TABLE_CHECK_EN
        check("pass_good",   {31'd0, bus1.pass}, 32'd1);
        check("err_f1_good", {16'd0, bus1.err_f1}, 32'd0);
        check("err_f2_good", {16'd0, bus1.err_f2}, 32'd0);
`endif

        // Results persist while idle.
        repeat (3) tick();
        check("persist_map_f1", {16'd0, bus1.map_f1}, 32'h35A5);

        // SETTLE=0, f1 tied 1, f2 tied 0: done at T+17, stim steps each cycle.
        push_exp(16'hFFFF, 16'h0000, 5'd16, 5'd0, 17);
        scan(1'b0, 1'b1, -1);

        // Start re-pulsed at idx=5 is ignored; single done at the original time.
        push_exp(16'h35A5, 16'hEEE2, 5'd8, 5'd10, 33);
        scan(1'b1, 1'b0, 5);
        watch_no_done("no_second_done", 40);

        // Faulty block: f2 minterm 6 stuck at 0.
        force_m6 = 1'b1;
        push_exp(16'h35A5, 16'hEEA2, 5'd8, 5'd9, 33);
        scan(1'b1, 1'b0, -1);
`ifdef TRUTH_TABLE_CHECK_EN
        check("pass_fault",   {31'd0, bus1.pass}, 32'd0);
        check("err_f1_fault", {16'd0, bus1.err_f1}, 32'd0);
        check("err_f2_fault", {16'd0, bus1.err_f2}, 32'h0040);
`endif
        force_m6 = 1'b0;

        // Reset at idx=9 aborts the scan with no done pulse.
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus1.stim == 4'd9) break;
            tick();
        end
        check("reached_idx9", {28'd0, bus1.stim}, 32'd9);
        rst = 1'b1;
        tick();
        check("abort_busy",   {31'd0, bus1.busy}, 32'd0);
        check("abort_done",   {31'd0, bus1.done}, 32'd0);
        check("abort_stim",   {28'd0, bus1.stim}, 32'd0);
        check("abort_map_f1", {16'd0, bus1.map_f1}, 32'd0);
        check("abort_map_f2", {16'd0, bus1.map_f2}, 32'd0);
        check("abort_cnt_f1", {27'd0, bus1.cnt_f1}, 32'd0);
        check("abort_cnt_f2", {27'd0, bus1.cnt_f2}, 32'd0);
`ifdef TRUTH_TABLE_CHECK_EN
        check("abort_pass",   {31'd0, bus1.pass}, 32'd0);
        check("abort_err_f2", {16'd0, bus1.err_f2}, 32'd0);
`endif
        rst = 1'b0;
        watch_no_done("no_done_after_abort", 40);
        check("idle_after_abort", {31'd0, bus1.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
